i2c_target: RTL and testbench

Write-only I2C target that receives the byte stream sent by the team's OLED/I2C controller and presents it to fabric logic for loopback testing on the board and in simulation. It samples `sck` and `sda` on the system clock and detects START, repeated START and STOP. It ACKs its own 7-bit address and every following data byte, and emits one strobe per received byte. It never stretches the clock and NACKs read requests.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_target_if.sv | 36 +++
 rtl/i2c_line_sync.sv | 84 ++++++++
 rtl/i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared definitions for the write-only I2C target:
//   - i2c_target_state_t : protocol state machine encoding
//   - I2C_ACK / I2C_NACK : value of the ninth bit as seen on the wire
//   - I2C_RW_WRITE       : R/W bit value for a controller write
//   - addr_write_match() : true when an address byte selects this target
//                          for a write
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_target_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

  localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;

  // Address byte on the wire is {addr[6:0], r/w}.
  function automatic logic addr_write_match(input logic [7:0] wire_byte,
                                            input logic [6:0] addr);
    return (wire_byte[7:1] == addr) && (wire_byte[0] == I2C_RW_WRITE);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// ---------------------------------------------------------------------------
// i2c_target_if
//   Receive-side bundle between the I2C target and fabric logic.
//   rx_data   : last received data byte, held until the next one completes
//   rx_valid  : one-cycle strobe, rx_data was updated
//   rx_first  : high with rx_valid for the first byte after the address
//   busy      : high from address match until STOP or START
//   frame_end : one-cycle strobe on STOP after an addressed transfer
//   modport master : producer side (the target)
//   modport slave  : consumer side (fabric logic)
// ---------------------------------------------------------------------------
interface i2c_target_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       busy;
  logic       frame_end;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_first,
    output busy,
    output frame_end
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_first,
    input busy,
    input frame_end
  );

endinterface

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
//   Conditions one asynchronous I2C line for use in the clk domain:
//   2-FF synchronizer, optional 3-sample majority filter, then a
//   previous-value register for edge detection.
//
//   Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN
//     defined   : majority filter inserted, single-cycle pulses rejected,
//                 edges visible 5 clk after the pin changes
//     undefined : no filter, edges visible 3 clk after the pin changes
//
//   Ports
//     clk     : system clock
//     rst_n   : asynchronous active-low reset
//     line_i  : raw pin value
//     level_o : conditioned line level
//     rise_o  : conditioned line rose this cycle
//     fall_o  : conditioned line fell this cycle
// ---------------------------------------------------------------------------
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic clean;
  logic prev_q;

  // Reset to 1: an idle I2C bus is pulled high, so leaving reset with a
  // released bus must not look like an edge.
  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic hist1_q;
  logic hist2_q;
  logic filt_q;

  // Output follows the majority of the last three synchronized samples,
  // so a pulse lasting one clk can never win a vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
      filt_q  <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end
  end

  assign clean = filt_q;
`else
  assign clean = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= clean;
    end
  end

  assign level_o = clean;
  assign rise_o  = clean & ~prev_q;
  assign fall_o  = ~clean & prev_q;

endmodule

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//   Write-only I2C target. Detects START / repeated START / STOP, ACKs its
//   7-bit address (write only) and every following data byte, and strobes
//   each received data byte out to fabric logic. Never stretches sck;
//   read requests and foreign addresses are left unacknowledged.
//
//   Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (majority filter
//   on both conditioned lines, see i2c_line_sync).
//
//   Parameters
//     ADDRESS : 7-bit target address (wire byte for a write is {ADDRESS,0})
//   Ports
//     clk   : system clock, all logic on its rising edge
//     rst_n : asynchronous active-low reset
//     sck   : I2C serial clock, input only
//     sda   : I2C data, open drain (driven 0 while ACKing, else z)
//     rx    : receive-side bundle (i2c_target_if.master)
// ---------------------------------------------------------------------------
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h3C
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sck,
  inout  wire          sda,
  i2c_target_if.master rx
);

  // -------------------------------------------------------------------------
  // Line conditioning and bus events
  // -------------------------------------------------------------------------
  logic sck_lvl, sck_rise, sck_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic bus_start, bus_stop;

  i2c_line_sync u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sck),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sda),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // sda may only change while sck is low, so any sda edge seen with sck
  // high is a bus condition rather than data.
  assign bus_start = sda_fall & sck_lvl;
  assign bus_stop  = sda_rise & sck_lvl;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  i2c_target_state_t state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              ack_bit_q, ack_bit_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_first_q, rx_first_d;
  logic              first_pending_q, first_pending_d;
  logic              busy_q, busy_d;
  logic              frame_end_q, frame_end_d;

  logic [7:0] shift_in;
  logic [3:0] cnt_inc;

  assign shift_in = {shift_q[6:0], sda_lvl};
  assign cnt_inc  = bit_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      ack_bit_q       <= I2C_NACK;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_first_q      <= 1'b0;
      first_pending_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_end_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      ack_bit_q       <= ack_bit_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_first_q      <= rx_first_d;
      first_pending_q <= first_pending_d;
      busy_q          <= busy_d;
      frame_end_q     <= frame_end_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    ack_bit_d       = ack_bit_q;
    rx_data_d       = rx_data_q;
    first_pending_d = first_pending_q;
    busy_d          = busy_q;
    rx_valid_d      = 1'b0;
    rx_first_d      = 1'b0;
    frame_end_d     = 1'b0;

    if (bus_start) begin
      // START (or repeated START) wins over any bit activity and discards
      // a partially received byte.
      state_d         = ST_ADDR;
      bit_cnt_d       = '0;
      shift_d         = '0;
      ack_bit_d       = I2C_NACK;
      busy_d          = 1'b0;
      first_pending_d = 1'b0;
    end else if (bus_stop) begin
      state_d         = ST_IDLE;
      bit_cnt_d       = '0;
      ack_bit_d       = I2C_NACK;
      frame_end_d     = busy_q;
      busy_d          = 1'b0;
      first_pending_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: begin
          // Wait for START or STOP, handled above.
        end

        ST_ADDR: begin
          if (sck_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == I2C_BITS_PER_BYTE) begin
              if (addr_write_match(shift_in, ADDRESS)) begin
                state_d         = ST_ADDR_ACK;
                busy_d          = 1'b1;
                first_pending_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_DATA_ACK: begin
          // First falling edge (end of bit 8) starts driving the ACK; the
          // next one (end of the ninth clock) releases the line.
          if (sck_fall) begin
            if (ack_bit_q == I2C_NACK) begin
              ack_bit_d = I2C_ACK;
            end else begin
              ack_bit_d = I2C_NACK;
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (sck_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == I2C_BITS_PER_BYTE) begin
              rx_data_d       = shift_in;
              rx_valid_d      = 1'b1;
              rx_first_d      = first_pending_q;
              first_pending_d = 1'b0;
              state_d         = ST_DATA_ACK;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Open drain: only ever pull low. ack_bit_q is cleared asynchronously by
  // reset, so the line is released the moment rst_n asserts.
  assign sda = (ack_bit_q == I2C_ACK) ? 1'b0 : 1'bz;

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.rx_first  = rx_first_q;
  assign rx.busy      = busy_q;
  assign rx.frame_end = frame_end_q;

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
//   Directed and randomized I2C write frames against i2c_target. Expected
//   receive streams come from a frame-level model: a frame addressed to
//   {ADDRESS,0} yields every data byte, the first flagged; any other
//   address byte yields nothing and no drive on sda.
// ---------------------------------------------------------------------------
module tb_i2c_target;

  localparam logic [6:0] ADDR = 7'h3C;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic scl     = 1'b1;
  logic sda_drv = 1'b1;   // 1 = release, 0 = pull low
  wire  sda;

  pullup (sda);
  assign sda = sda_drv ? 1'bz : 1'b0;

  i2c_target_if rx_if ();

  i2c_target #(.ADDRESS(ADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sck   (scl),
    .sda   (sda),
    .rx    (rx_if.master)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Monitor: records strobes; samples on the falling clk edge
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } rx_t;

  rx_t rx_q[$];
  int  fe_cnt      = 0;
  int  dut_low_cnt = 0;

  always @(negedge clk) begin
    if (rx_if.rx_valid) rx_q.push_back({rx_if.rx_first, rx_if.rx_data});
    if (rx_if.frame_end) fe_cnt++;
    if (sda_drv && (sda == 1'b0)) dut_low_cnt++;
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Bus driver (inputs change 1 time unit after a rising clk edge)
  // -------------------------------------------------------------------------
  int q = 68;   // clk cycles per quarter SCL period

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda_drv = 1'b1; tick(q);
      scl     = 1'b1; tick(q);
    end
    sda_drv = 1'b0; tick(q);
    scl     = 1'b0; tick(q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(q);
    scl     = 1'b1; tick(q);
    sda_drv = 1'b1; tick(2 * q);
  endtask

  // glitch: one-clk high pulse on sda in the middle of the sck-high phase
  task automatic send_bit(input logic b, input logic glitch);
    sda_drv = b; tick(q);
    scl = 1'b1;
    if (glitch) begin
      tick(q);
      sda_drv = 1'b1; tick(1);
      sda_drv = b;    tick(q - 1);
    end else begin
      tick(2 * q);
    end
    scl = 1'b0; tick(q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    sda_drv = 1'b1; tick(q);
    scl = 1'b1; tick(q);
    acked = (sda == 1'b0);
    tick(q);
    scl = 1'b0; tick(q);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic       ack;
  logic [7:0] abyte;
  logic [7:0] bytes[$];
  logic [7:0] tmp;
  int         kind;
  int         n;
  logic       match;
  int         fe0;
  int         low0;

  initial begin
    // Reset state
    tick(4);
    check("reset rx_data",   rx_if.rx_data,   8'h00);
    check("reset rx_valid",  rx_if.rx_valid,  1'b0);
    check("reset rx_first",  rx_if.rx_first,  1'b0);
    check("reset busy",      rx_if.busy,      1'b0);
    check("reset frame_end", rx_if.frame_end, 1'b0);
    check("reset sda",       sda,             1'b1);
    rst_n = 1'b1;
    tick(10);

    // 1: addressed write at ~100 kHz SCL with a 27 MHz clk (270 clk/bit)
    q = 68;
    rx_q.delete(); fe0 = fe_cnt;
    bus_start();
    send_byte(8'h78, -1, ack); check("t1 addr ack", ack, 1'b1);
    check("t1 busy", rx_if.busy, 1'b1);
    send_byte(8'h00, -1, ack); check("t1 data0 ack", ack, 1'b1);
    send_byte(8'h8D, -1, ack); check("t1 data1 ack", ack, 1'b1);
    bus_stop();
    check("t1 rx count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("t1 rx0", rx_q[0], {1'b1, 8'h00});
      check("t1 rx1", rx_q[1], {1'b0, 8'h8D});
    end
    check("t1 frame_end", fe_cnt - fe0, 1);
    check("t1 busy after stop", rx_if.busy, 1'b0);
    check("t1 rx_data held", rx_if.rx_data, 8'h8D);

    // 2: foreign address
    q = 10;
    rx_q.delete(); fe0 = fe_cnt; low0 = dut_low_cnt;
    bus_start();
    send_byte(8'h7A, -1, ack); check("t2 addr nack", ack, 1'b0);
    check("t2 busy", rx_if.busy, 1'b0);
    send_byte(8'h14, -1, ack); check("t2 data nack", ack, 1'b0);
    bus_stop();
    check("t2 rx count", rx_q.size(), 0);
    check("t2 frame_end", fe_cnt - fe0, 0);
    check("t2 no drive", dut_low_cnt - low0, 0);

    // 3: read request to our address
    rx_q.delete(); fe0 = fe_cnt; low0 = dut_low_cnt;
    bus_start();
    send_byte(8'h79, -1, ack); check("t3 read nack", ack, 1'b0);
    check("t3 busy", rx_if.busy, 1'b0);
    bus_stop();
    check("t3 rx count", rx_q.size(), 0);
    check("t3 frame_end", fe_cnt - fe0, 0);
    check("t3 no drive", dut_low_cnt - low0, 0);

    // 4: partial byte abandoned by a repeated START
    rx_q.delete(); fe0 = fe_cnt;
    tmp = 8'hAF;
    bus_start();
    send_byte(8'h78, -1, ack); check("t4 addr ack", ack, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(tmp[i], 1'b0);
    bus_start();
    send_byte(8'h78, -1, ack); check("t4 re-addr ack", ack, 1'b1);
    send_byte(8'hAF, -1, ack); check("t4 data ack", ack, 1'b1);
    bus_stop();
    check("t4 rx count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("t4 rx0", rx_q[0], {1'b1, 8'hAF});
    check("t4 frame_end", fe_cnt - fe0, 1);

    // 5: reset while the address ACK is being driven
    tmp = 8'h78;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(tmp[i], 1'b0);
    sda_drv = 1'b1; tick(q);
    check("t5 ack driven", sda, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5 sda released in reset", sda, 1'b1);
    check("t5 busy in reset", rx_if.busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(q);
    scl = 1'b1; tick(2 * q);
    rx_q.delete(); fe0 = fe_cnt;
    bus_start();
    send_byte(8'h78, -1, ack); check("t5 addr ack", ack, 1'b1);
    send_byte(8'h3C, -1, ack); check("t5 data ack", ack, 1'b1);
    bus_stop();
    check("t5 rx count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("t5 rx0", rx_q[0], {1'b1, 8'h3C});
    check("t5 frame_end", fe_cnt - fe0, 1);

    // 6: one-clk high glitch on sda while sck is high, mid data byte
    rx_q.delete(); fe0 = fe_cnt;
    bus_start();
    send_byte(8'h78, -1, ack); check("t6 addr ack", ack, 1'b1);
    send_byte(8'h5A, 5, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("t6 data ack", ack, 1'b1);
    check("t6 busy", rx_if.busy, 1'b1);
    check("t6 frame_end before stop", fe_cnt - fe0, 0);
    bus_stop();
    check("t6 rx count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("t6 rx0", rx_q[0], {1'b1, 8'h5A});
`else
    // Unfiltered: the glitch reads as STOP, its trailing fall as START.
    check("t6 data ack", ack, 1'b0);
    check("t6 busy", rx_if.busy, 1'b0);
    check("t6 frame_end before stop", fe_cnt - fe0, 1);
    bus_stop();
    check("t6 rx count", rx_q.size(), 0);
`endif
    check("t6 frame_end", fe_cnt - fe0, 1);

    // Randomized frames against the frame-level model
    for (int f = 0; f < 8; f++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: abyte = {ADDR, 1'b0};
        2: begin
          abyte = {7'($urandom_range(0, 127)), 1'b0};
          if (abyte[7:1] == ADDR) abyte[7:1] = ADDR + 7'd1;
        end
        default: abyte = {ADDR, 1'b1};
      endcase
      n = (kind == 3) ? 0 : $urandom_range(1, 3);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));
      match = (abyte == {ADDR, 1'b0});

      rx_q.delete(); fe0 = fe_cnt; low0 = dut_low_cnt;
      bus_start();
      send_byte(abyte, -1, ack); check("rnd addr ack", ack, match);
      check("rnd busy", rx_if.busy, match);
      for (int i = 0; i < n; i++) begin
        send_byte(bytes[i], -1, ack); check("rnd data ack", ack, match);
      end
      bus_stop();

      check("rnd rx count", rx_q.size(), match ? n : 0);
      if (match && (rx_q.size() == n)) begin
        for (int i = 0; i < n; i++) check("rnd rx byte", rx_q[i], {(i == 0), bytes[i]});
      end
      check("rnd frame_end", fe_cnt - fe0, match);
      if (!match) check("rnd no drive", dut_low_cnt - low0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
